// File: rtl/rv32_mod_lsu_pipelined.sv
// RV32 LSU: issue register -> bus request (1 cycle), meta FIFO of DEPTH outstanding, completion pulse 1 cycle after response.
// Stall while issue entry is not granted/faulted; LSU_MISALIGNED_EN splits word-crossing accesses into two beats.
module rv32_mod_lsu_pipelined #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [3:0]  req_type,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid,
  output logic        error,
  output logic        stall,
  output logic        dext_req,
  input  logic        dext_gnt,
  output logic        dext_wr,
  output logic [3:0]  dext_be,
  output logic [31:0] dext_addr,
  output logic [31:0] dext_do,
  input  logic        dext_ack,
  input  logic        dext_err,
  input  logic [31:0] dext_di
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // split: 0 = single beat, 1 = first beat of a pair, 2 = second beat
  typedef struct packed {
    logic       wr;
    logic       sgn;
    logic [1:0] size;
    logic [1:0] off;
    logic       fault;
    logic [1:0] split;
  } meta_t;

  logic          r_iss_vld;
  logic [31:0]   r_iss_addr;
  logic [3:0]    r_iss_be;
  logic [31:0]   r_iss_do;
  meta_t         r_iss_m;

  meta_t         r_fifo [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_to_cnt;

  logic [3:0]    w_mask;
  logic [7:0]    w_lanes;
  logic          w_misal;
  logic [63:0]   w_dd;
  meta_t         w_new_m;
  logic          w_room;
  logic          w_grant;
  logic          w_fault_push;
  logic          w_iss_done;
  logic          w_accept;
  logic          w_push;
  meta_t         w_head;
  logic          w_hvld;
  logic          w_rsp;
  logic          w_pop_fault;
  logic          w_pop_rsp;
  logic          w_pop_to;
  logic          w_pop;
  logic          w_beat_err;
  logic          w_err_all;
  logic          w_emit;
  logic [63:0]   w_raw;
  logic [63:0]   w_sh;
  logic [31:0]   w_ext;
  logic          w_unused;

`ifdef LSU_MISALIGNED_EN
  logic [3:0]    r_iss_be1;
  logic [31:0]   r_mrg_dat;
  logic          r_mrg_err;
`endif

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------- request decode ----------------
  always_comb begin
    w_mask = 4'b0000;
    case (req_type[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      2'b10:   w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  assign w_lanes = {4'b0000, w_mask} << address[1:0];
  assign w_misal = ((req_type[1:0] == 2'b01) && address[0]) ||
                   ((req_type[1:0] == 2'b10) && (address[1:0] != 2'b00));
  assign w_dd    = {data_i, data_i} << {address[1:0], 3'b000};

  always_comb begin
    w_new_m      = '0;
    w_new_m.wr   = wr;
    w_new_m.sgn  = req_type[3];
    w_new_m.size = req_type[1:0];
    w_new_m.off  = address[1:0];
`ifdef LSU_MISALIGNED_EN
    // a misaligned half that stays inside one word needs only one beat
    w_new_m.fault = (req_type[1:0] == 2'b11);
    w_new_m.split = (|w_lanes[7:4]) ? 2'd1 : 2'd0;
`else
    w_new_m.fault = (req_type[1:0] == 2'b11) || w_misal;
    w_new_m.split = 2'd0;
`endif
  end

  // ---------------- issue stage ----------------
  assign w_room       = (r_iss_m.split == 2'd1) ? ((int'(r_cnt) + 2) <= DEPTH) : (r_cnt < DEPTH_C);
  assign dext_req     = r_iss_vld && !r_iss_m.fault && w_room;
  assign w_grant      = dext_req && dext_gnt;
  assign w_fault_push = r_iss_vld && r_iss_m.fault && (r_cnt < DEPTH_C);
  assign w_iss_done   = (w_grant && (r_iss_m.split != 2'd1)) || w_fault_push;
  assign stall        = r_iss_vld && !w_iss_done;
  assign w_accept     = req && !stall;
  assign w_push       = w_grant || w_fault_push;

  assign dext_wr   = r_iss_m.wr;
  assign dext_be   = r_iss_be;
  assign dext_addr = r_iss_addr;
  assign dext_do   = r_iss_do;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iss_vld  <= 1'b0;
      r_iss_addr <= '0;
      r_iss_be   <= '0;
      r_iss_do   <= '0;
      r_iss_m    <= '0;
`ifdef LSU_MISALIGNED_EN
      r_iss_be1  <= '0;
`endif
    end else if (w_accept) begin
      r_iss_vld  <= 1'b1;
      r_iss_addr <= {address[31:2], 2'b00};
      r_iss_be   <= w_lanes[3:0];
      r_iss_do   <= w_dd[63:32];
      r_iss_m    <= w_new_m;
`ifdef LSU_MISALIGNED_EN
      r_iss_be1  <= w_lanes[7:4];
`endif
    end else if (w_iss_done) begin
      r_iss_vld  <= 1'b0;
`ifdef LSU_MISALIGNED_EN
    end else if (w_grant) begin
      r_iss_addr    <= r_iss_addr + 32'd4;
      r_iss_be      <= r_iss_be1;
      r_iss_m.split <= 2'd2;
`endif
    end
  end

  // ---------------- meta FIFO ----------------
  assign w_head      = r_fifo[r_rptr];
  assign w_hvld      = (r_cnt != '0);
  assign w_rsp       = dext_ack || dext_err;
  assign w_pop_fault = w_hvld && w_head.fault;
  assign w_pop_rsp   = w_hvld && !w_head.fault && w_rsp;
  assign w_pop_to    = (TIMEOUT > 0) && w_hvld && !w_head.fault && !w_rsp && (r_to_cnt == TO_LAST);
  assign w_pop       = w_pop_fault || w_pop_rsp || w_pop_to;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= r_iss_m;
        r_wptr         <= f_inc(r_wptr);
      end
      if (w_pop) r_rptr <= f_inc(r_rptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_to_cnt <= '0;
    else if (!w_hvld || w_pop) r_to_cnt <= '0;
    else                       r_to_cnt <= r_to_cnt + TW'(1);
  end

  // ---------------- completion ----------------
  assign w_beat_err = w_head.fault || w_pop_to || dext_err;
  assign w_emit     = w_pop && (w_head.split != 2'd1);

`ifdef LSU_MISALIGNED_EN
  assign w_raw     = (w_head.split == 2'd2) ? {dext_di, r_mrg_dat} : {32'd0, dext_di};
  assign w_err_all = w_beat_err || ((w_head.split == 2'd2) && r_mrg_err);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mrg_dat <= '0;
      r_mrg_err <= 1'b0;
    end else if (w_pop && (w_head.split == 2'd1)) begin
      r_mrg_dat <= dext_di;
      r_mrg_err <= w_beat_err;
    end
  end
`else
  assign w_raw     = {32'd0, dext_di};
  assign w_err_all = w_beat_err;
`endif

  assign w_sh = w_raw >> {w_head.off, 3'b000};

  always_comb begin
    w_ext = w_sh[31:0];
    case (w_head.size)
      2'b00:   w_ext = {{24{w_head.sgn & w_sh[7]}},  w_sh[7:0]};
      2'b01:   w_ext = {{16{w_head.sgn & w_sh[15]}}, w_sh[15:0]};
      default: w_ext = w_sh[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid  <= 1'b0;
      error  <= 1'b0;
      data_o <= '0;
    end else begin
      valid  <= w_emit && !w_err_all;
      error  <= w_emit && w_err_all;
      data_o <= (w_emit && !w_err_all && !w_head.wr) ? w_ext : 32'd0;
    end
  end

  assign w_unused = ^{req_type[2], w_lanes[7:4], w_misal, w_sh[63:32], w_pop_rsp};

endmodule

// File: tb/tb_rv32_mod_lsu_pipelined.sv
// Directed bench for rv32_mod_lsu_pipelined (DEPTH=4, TIMEOUT=8); LSU_MISALIGNED_EN selects the split-access vector.
`timescale 1ns/1ps
module tb_rv32_mod_lsu_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [3:0]  req_type;
  logic        wr;
  logic [31:0] address;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        valid;
  logic        error;
  logic        stall;
  logic        dext_req;
  logic        dext_gnt;
  logic        dext_wr;
  logic [3:0]  dext_be;
  logic [31:0] dext_addr;
  logic [31:0] dext_do;
  logic        dext_ack;
  logic        dext_err;
  logic [31:0] dext_di;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32_mod_lsu_pipelined #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_type(req_type), .wr(wr),
    .address(address), .data_i(data_i), .data_o(data_o), .valid(valid),
    .error(error), .stall(stall), .dext_req(dext_req), .dext_gnt(dext_gnt),
    .dext_wr(dext_wr), .dext_be(dext_be), .dext_addr(dext_addr), .dext_do(dext_do),
    .dext_ack(dext_ack), .dext_err(dext_err), .dext_di(dext_di)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] t, input logic w, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; req_type = t; wr = w; address = a; data_i = d;
    #1;
    chk("stall_at_accept", 32'(stall), 32'd0);
    tick();
    req = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic v, input logic e, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(valid), 32'(v));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_data"},  data_o, d);
  endtask

  logic [3:0]  vt   [6] = '{4'b1000, 4'b1001, 4'b0000, 4'b0001, 4'b0010, 4'b1010};
  logic [31:0] va   [6] = '{32'h1003, 32'h1002, 32'h1001, 32'h1000, 32'h1004, 32'h1008};
  logic [31:0] vdi  [6] = '{32'h80FF_0000, 32'h8001_0000, 32'h0000_AB00, 32'h0000_8001, 32'hCAFE_F00D, 32'h8000_0000};
  logic [3:0]  vbe  [6] = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b1111};
  logic [31:0] vexp [6] = '{32'hFFFF_FF80, 32'hFFFF_8001, 32'h0000_00AB, 32'h0000_8001, 32'hCAFE_F00D, 32'h8000_0000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; req = 1'b0; req_type = '0; wr = 1'b0; address = '0; data_i = '0;
    dext_gnt = 1'b0; dext_ack = 1'b0; dext_err = 1'b0; dext_di = '0;
    tick(); tick();
    chk("rst_dext_req", 32'(dext_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk_done("rst", 1'b0, 1'b0, 32'd0);
    reset_n = 1'b1;
    tick();

    // single loads: lane select and extension, ack three cycles after grant
    for (int i = 0; i < 6; i++) begin
      drive_req(vt[i], 1'b0, va[i], 32'd0);
      dext_gnt = 1'b1;
      #1;
      chk("ld_req", 32'(dext_req), 32'd1);
      chk("ld_wr", 32'(dext_wr), 32'd0);
      chk("ld_addr", dext_addr, va[i] & 32'hFFFF_FFFC);
      chk("ld_be", 32'(dext_be), 32'(vbe[i]));
      tick();
      dext_gnt = 1'b0;
      #1;
      chk("ld_req_drop", 32'(dext_req), 32'd0);
      tick(); tick();
      chk("ld_no_early", 32'(valid), 32'd0);
      dext_ack = 1'b1; dext_di = vdi[i];
      tick();
      dext_ack = 1'b0;
      #1;
      chk_done("ld", 1'b1, 1'b0, vexp[i]);
      tick();
      chk("ld_one_cycle", 32'(valid), 32'd0);
    end

    // back-to-back loads with grant every cycle
    req = 1'b1; req_type = 4'b0010; wr = 1'b0; address = 32'h2000;
    #1;
    chk("b2b_stall0", 32'(stall), 32'd0);
    tick();
    for (int i = 1; i < 5; i++) begin
      dext_gnt = 1'b1; address = 32'h2000 + 32'(4 * i);
      #1;
      chk("b2b_stall", 32'(stall), 32'd0);
      chk("b2b_addr", dext_addr, 32'h2000 + 32'(4 * (i - 1)));
      tick();
    end
    req = 1'b0;
    #1;
    chk("full_req", 32'(dext_req), 32'd0);
    chk("full_stall", 32'(stall), 32'd1);
    dext_ack = 1'b1; dext_di = 32'h1111_1111;
    tick();
    chk("fifth_req", 32'(dext_req), 32'd1);
    chk("fifth_addr", dext_addr, 32'h2010);
    for (int k = 1; k < 5; k++) begin
      chk_done("b2b", 1'b1, 1'b0, 32'h1111_1111 * 32'(k));
      dext_di = 32'h1111_1111 * 32'(k + 1);
      tick();
      dext_gnt = 1'b0;
    end
    dext_ack = 1'b0;
    #1;
    chk_done("b2b_last", 1'b1, 1'b0, 32'h5555_5555);
    tick();

    // halfword store to upper lanes
    drive_req(4'b0001, 1'b1, 32'h1002, 32'h0000_ABCD);
    dext_gnt = 1'b1;
    #1;
    chk("sh_req", 32'(dext_req), 32'd1);
    chk("sh_wr", 32'(dext_wr), 32'd1);
    chk("sh_addr", dext_addr, 32'h1000);
    chk("sh_be", 32'(dext_be), 32'hC);
    chk("sh_do", dext_do, 32'hABCD_0000);
    tick();
    dext_gnt = 1'b0; dext_ack = 1'b1; dext_di = 32'hDEAD_BEEF;
    tick();
    dext_ack = 1'b0;
    #1;
    chk_done("sh", 1'b1, 1'b0, 32'd0);
    tick();

    // misaligned word
    drive_req(4'b0010, 1'b0, 32'h1001, 32'd0);
`ifdef LSU_MISALIGNED_EN
    dext_gnt = 1'b1;
    #1;
    chk("mis_b0_addr", dext_addr, 32'h1000);
    chk("mis_b0_be", 32'(dext_be), 32'hE);
    chk("mis_b0_stall", 32'(stall), 32'd1);
    tick();
    chk("mis_b1_req", 32'(dext_req), 32'd1);
    chk("mis_b1_addr", dext_addr, 32'h1004);
    chk("mis_b1_be", 32'(dext_be), 32'h1);
    tick();
    dext_gnt = 1'b0; dext_ack = 1'b1; dext_di = 32'h3322_1100;
    tick();
    dext_di = 32'h7766_5544;
    #1;
    chk("mis_no_early", 32'(valid), 32'd0);
    tick();
    dext_ack = 1'b0;
    #1;
    chk_done("mis", 1'b1, 1'b0, 32'h4433_2211);
    tick();
`else
    #1;
    chk("mis_no_req", 32'(dext_req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    chk("mis_no_early", 32'(error), 32'd0);
    tick();
    chk_done("mis", 1'b0, 1'b1, 32'd0);
    tick();
`endif

    // illegal size queued behind an outstanding load completes in order
    drive_req(4'b0010, 1'b0, 32'h3000, 32'd0);
    dext_gnt = 1'b1;
    drive_req(4'b0011, 1'b0, 32'h3000, 32'd0);
    dext_gnt = 1'b0;
    #1;
    chk("ill_no_req", 32'(dext_req), 32'd0);
    tick();
    chk_done("ill_wait", 1'b0, 1'b0, 32'd0);
    dext_ack = 1'b1; dext_di = 32'h1234_5678;
    tick();
    dext_ack = 1'b0;
    #1;
    chk_done("ill_first", 1'b1, 1'b0, 32'h1234_5678);
    tick();
    chk_done("ill_second", 1'b0, 1'b1, 32'd0);
    tick();

    // timeout: error nine cycles after the grant cycle, then FIFO empty
    drive_req(4'b0010, 1'b0, 32'h4000, 32'd0);
    dext_gnt = 1'b1;
    tick();
    dext_gnt = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_not_yet", 32'(error), 32'd0);
    tick();
    chk_done("to", 1'b0, 1'b1, 32'd0);
    dext_ack = 1'b1; dext_di = 32'hFFFF_FFFF;
    tick();
    dext_ack = 1'b0;
    #1;
    chk_done("to_empty_rsp", 1'b0, 1'b0, 32'd0);
    tick();

    // ack and err together
    drive_req(4'b0010, 1'b0, 32'h5000, 32'd0);
    dext_gnt = 1'b1;
    tick();
    dext_gnt = 1'b0; dext_ack = 1'b1; dext_err = 1'b1; dext_di = 32'hFFFF_FFFF;
    tick();
    dext_ack = 1'b0; dext_err = 1'b0;
    #1;
    chk_done("ackerr", 1'b0, 1'b1, 32'd0);
    tick();

    // reset with three requests outstanding
    req = 1'b1; req_type = 4'b0010; wr = 1'b0; address = 32'h6000;
    tick();
    dext_gnt = 1'b1; address = 32'h6004;
    tick();
    address = 32'h6008;
    tick();
    address = 32'h600C;
    tick();
    req = 1'b0; dext_ack = 1'b1; dext_di = 32'h0BAD_F00D;
    tick();
    dext_gnt = 1'b0; dext_ack = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dext_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk_done("mid_rst", 1'b0, 1'b0, 32'd0);
    tick();
    chk("mid_rst_stall2", 32'(stall), 32'd0);
    reset_n = 1'b1;
    tick();
    dext_ack = 1'b1; dext_di = 32'h0BAD_F00D;
    tick();
    dext_ack = 1'b0;
    #1;
    chk_done("stale_rsp", 1'b0, 1'b0, 32'd0);
    drive_req(4'b0010, 1'b0, 32'h7000, 32'd0);
    dext_gnt = 1'b1;
    #1;
    chk("post_rst_addr", dext_addr, 32'h7000);
    tick();
    dext_gnt = 1'b0; dext_ack = 1'b1; dext_di = 32'h600D_CAFE;
    tick();
    dext_ack = 1'b0;
    #1;
    chk_done("post_rst", 1'b1, 1'b0, 32'h600D_CAFE);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
